cacheline_adaptor: RTL and testbench
====================================

# cacheline_adaptor

Responder on the physical-memory side of the cache: accepts one 256-bit line read or write from the cache (`pmem_*` port group) and converts it into a 4-beat, 64-bit burst toward main memory. Sits between the cache's `pmem_address`/`pmem_rdata`/`pmem_wdata` port group and the memory model or bus. It has one request in flight, with no queueing.

## Interface
- `LINE_W`, 256, cache line width (bits)
- `BEAT_W`, 64, memory beat width; `LINE_W/BEAT_W` = 4 beats
- `clk`  in  1  system clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `address_i`  in  32  line address from cache
- `line_i`  in  256  write line from cache (`pmem_wdata`)
- `read_i`  in  1  cache line read request, level, held until `resp_o`
- `write_i`  in  1  cache line write request, level, held until `resp_o`
- `line_o`  out  256  assembled read line to cache (`pmem_rdata`)
- `resp_o`  out  1  one-cycle completion pulse to cache
- `address_o`  out  32  burst address to memory
- `burst_i`  in  64  read beat from memory
- `burst_o`  out  64  write beat to memory
- `read_o`  out  1  memory read request, held for the whole burst
- `write_o`  out  1  memory write request, held for the whole burst
- `resp_i`  in  1  memory beat acknowledge, one pulse per beat

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE
  - If `read_i`: latch `{address_i[31:5], 5'b0}`, clear the beat counter, go to READ.
  - Else if `write_i`: latch the aligned address, copy `line_i` into the line buffer, clear the beat counter, go to WRITE.
  - If both are asserted, the read is taken and the write is ignored.
- READ
  - `read_o`=1 and `address_o`=latched address.
  - Each cycle with `resp_i`=1: `buffer[beat*64 +: 64] <= burst_i`, then `beat++`.
  - `resp_i` with beat==3: go to DONE.
- WRITE
  - `write_o`=1, `address_o`=latched address, `burst_o`=`buffer[beat*64 +: 64]` (beat 0 = bits 63:0).
  - On `resp_i`: `beat++`.
  - `resp_i` with beat==3: go to DONE.
- DONE
  - `resp_o`=1 for exactly one cycle, then go to IDLE.
  - `read_o` and `write_o` are 0 in DONE.
- `line_o` is driven from the line buffer at all times.
  - After a read it holds the new line until the next transaction modifies the buffer.
  - A write overwrites the buffer, so `line_o` then shows the written line.
- Beat counter: 2 bits, wraps 3→0. It only advances on `resp_i` in READ/WRITE.
- `resp_i` is ignored in IDLE and DONE.
- Changes on `address_i`, `line_i`, `read_i` or `write_i` during READ/WRITE/DONE are ignored; latched values are used.
- Cache obligation: drop `read_i`/`write_i` in the cycle after `resp_o`. A request still high in IDLE starts a new transaction.

## Timing
- Reset (asynchronous, `rst_n`=0): state IDLE, beat 0, buffer 0, latched address 0.
- Output values during and after reset:
  - `resp_o`, `read_o`, `write_o` = 0
  - `address_o`, `burst_o` = 0
  - `line_o` = 0
- Reset mid-burst aborts the transaction: no `resp_o`, and memory requests drop immediately.
- Request sampled at edge E0 in IDLE: `read_o`/`write_o` high from cycle 1.
- With `resp_i` on every cycle, beats complete in cycles 1–4, `resp_o` is high in cycle 5, and IDLE is reached in cycle 6.
  - Minimum request-to-`resp_o` latency: 5 cycles.
  - Minimum back-to-back spacing: 6 cycles.
- Wait states: every cycle with `resp_i`=0 in READ/WRITE adds one cycle. `burst_o` is held stable until its beat is acknowledged.
- All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.

## Structure
- Package `cacheline_adaptor_pkg`:
  - state enum `ca_state_e` (IDLE, READ, WRITE, DONE)
  - constants `CA_LINE_W`=256, `CA_BEAT_W`=64, `CA_BEATS`=4
- Single module: one FSM, one 256-bit buffer, one 2-bit counter, one address register. No sub-module.

## Test plan
- Read, zero-wait:
  - Stimulus: `read_i` with `address_i`=0x0000_1234; `burst_i`=0x11..11, 0x22..22, 0x33..33, 0x44..44 with `resp_i` each cycle.
  - Required: `address_o`=0x0000_1220; `resp_o` in cycle 5; `line_o`={0x44..,0x33..,0x22..,0x11..}.
- Write, 2 wait cycles before beat 2:
  - Stimulus: `line_i`=0xDDDD..CCCC..BBBB..AAAA; `resp_i` withheld for 2 cycles before beat 2.
  - Required: `burst_o` sequence AAAA.., BBBB.., CCCC.., DDDD.., each held until acked; `resp_o` in cycle 7.
- Simultaneous `read_i` and `write_i` → read burst only; `write_o` stays 0 throughout.
- Reset mid-burst:
  - Stimulus: assert `rst_n`=0 after beat 2 of a read.
  - Required: `read_o`/`resp_o` drop asynchronously; `line_o`=0; a subsequent read completes normally.
- Spurious `resp_i` in IDLE and DONE → no state change, beat counter unchanged. Back-to-back read then write → second `resp_o` exactly 6 cycles after the first (zero-wait).

Source files
------------

// File: rtl/cacheline_adaptor_pkg.sv
// cacheline_adaptor_pkg
// Shared types and sizing constants for the cache-line-to-burst adaptor.
//   ca_state_e : transaction FSM states
//   CA_LINE_W  : cache line width in bits
//   CA_BEAT_W  : memory beat width in bits
//   CA_BEATS   : beats per line
package cacheline_adaptor_pkg;

  localparam int unsigned CA_LINE_W = 256;
  localparam int unsigned CA_BEAT_W = 64;
  localparam int unsigned CA_BEATS  = CA_LINE_W / CA_BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    WRITE,
    DONE
  } ca_state_e;

endpackage

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor
// Takes one cache line read or write from the cache and performs it as a burst of
// LINE_W/BEAT_W beats toward main memory. Only one transaction is in flight.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   address_i   : line address from cache (low offset bits ignored)
//   line_i      : line to write, captured when a write is accepted
//   read_i      : cache read request, level, held until resp_o
//   write_i     : cache write request, level, held until resp_o
//   line_o      : line buffer contents (read result or last written line)
//   resp_o      : one-cycle completion pulse to cache
//   address_o   : line-aligned burst address to memory
//   burst_i     : read beat from memory
//   burst_o     : write beat to memory, held until acknowledged
//   read_o      : memory read request, high for the whole burst
//   write_o     : memory write request, high for the whole burst
//   resp_i      : memory beat acknowledge, one pulse per beat
module cacheline_adaptor
  import cacheline_adaptor_pkg::*;
#(
  parameter int unsigned LINE_W = CA_LINE_W,
  parameter int unsigned BEAT_W = CA_BEAT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       address_i,
  input  logic [LINE_W-1:0] line_i,
  input  logic              read_i,
  input  logic              write_i,
  output logic [LINE_W-1:0] line_o,
  output logic              resp_o,
  output logic [31:0]       address_o,
  input  logic [BEAT_W-1:0] burst_i,
  output logic [BEAT_W-1:0] burst_o,
  output logic              read_o,
  output logic              write_o,
  input  logic              resp_i
);

  localparam int unsigned        Beats    = LINE_W / BEAT_W;
  localparam int unsigned        BeatIdxW = $clog2(Beats);
  localparam logic [BeatIdxW-1:0] LastBeat = BeatIdxW'(Beats - 1);
  // Byte-offset bits within a line are forced to zero.
  localparam logic [31:0]        OffMask  = 32'(LINE_W / 8 - 1);

  ca_state_e           state_q;
  logic [BeatIdxW-1:0] beat_q;
  logic [LINE_W-1:0]   buf_q;
  logic [31:0]         addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_q  <= '0;
      buf_q   <= '0;
      addr_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // Read has priority when both requests are raised together.
          if (read_i) begin
            addr_q  <= address_i & ~OffMask;
            beat_q  <= '0;
            state_q <= READ;
          end else if (write_i) begin
            addr_q  <= address_i & ~OffMask;
            buf_q   <= line_i;
            beat_q  <= '0;
            state_q <= WRITE;
          end
        end
        READ: begin
          if (resp_i) begin
            buf_q[int'(beat_q) * BEAT_W +: BEAT_W] <= burst_i;
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= DONE;
          end
        end
        WRITE: begin
          if (resp_i) begin
            beat_q <= beat_q + 1'b1;
            if (beat_q == LastBeat) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; no input reaches an output combinationally.
  always_comb begin
    read_o    = (state_q == READ);
    write_o   = (state_q == WRITE);
    resp_o    = (state_q == DONE);
    address_o = addr_q;
    line_o    = buf_q;
    burst_o   = '0;
    if (state_q == WRITE) burst_o = buf_q[int'(beat_q) * BEAT_W +: BEAT_W];
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
module tb_cacheline_adaptor;

  logic         clk;
  logic         rst_n;
  logic [31:0]  address_i;
  logic [255:0] line_i;
  logic         read_i;
  logic         write_i;
  logic [255:0] line_o;
  logic         resp_o;
  logic [31:0]  address_o;
  logic [63:0]  burst_i;
  logic [63:0]  burst_o;
  logic         read_o;
  logic         write_o;
  logic         resp_i;

  cacheline_adaptor dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .address_i (address_i),
    .line_i    (line_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .line_o    (line_o),
    .resp_o    (resp_o),
    .address_o (address_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs applied before an edge, outputs expected just after it.
  typedef struct {
    logic        rd;
    logic        wr;
    logic        rsp;
    logic [63:0] burst;
    logic        e_rd;
    logic        e_wr;
    logic        e_resp;
    logic [63:0] e_bo;
  } vec_t;

  vec_t vecs[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic logic [63:0] rep(input logic [3:0] n);
    return {16{n}};
  endfunction

  task automatic add(input logic rd, input logic wr, input logic rsp, input logic [63:0] burst,
                     input logic e_rd, input logic e_wr, input logic e_resp,
                     input logic [63:0] e_bo);
    vec_t v;
    v.rd = rd; v.wr = wr; v.rsp = rsp; v.burst = burst;
    v.e_rd = e_rd; v.e_wr = e_wr; v.e_resp = e_resp; v.e_bo = e_bo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_seg(input string tag, input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      read_i  = vecs[i].rd;
      write_i = vecs[i].wr;
      resp_i  = vecs[i].rsp;
      burst_i = vecs[i].burst;
      step();
      chk($sformatf("%s[%0d].read_o", tag, i - lo), 256'(read_o), 256'(vecs[i].e_rd));
      chk($sformatf("%s[%0d].write_o", tag, i - lo), 256'(write_o), 256'(vecs[i].e_wr));
      chk($sformatf("%s[%0d].resp_o", tag, i - lo), 256'(resp_o), 256'(vecs[i].e_resp));
      chk($sformatf("%s[%0d].burst_o", tag, i - lo), 256'(burst_o), 256'(vecs[i].e_bo));
    end
  endtask

  logic [255:0] wline;
  int a_lo, a_hi, b_lo, b_hi, c_lo, c_hi, d_lo, d_mid, d_hi;

  initial begin
    wline = {rep(4'hD), rep(4'hC), rep(4'hB), rep(4'hA)};

    // A: zero-wait read; resp_o after the 5th edge.
    a_lo = vecs.size();
    add(1, 0, 0, 64'h0,      1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'h1),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'h2),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'h3),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'h4),  0, 0, 1, 64'h0);
    add(1, 0, 0, 64'h0,      0, 0, 0, 64'h0);
    add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0);
    a_hi = vecs.size();

    // B: write, two wait cycles before beat 2; resp_o after the 7th edge.
    b_lo = vecs.size();
    add(0, 1, 0, 64'h0,      0, 1, 0, rep(4'hA));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hB));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hC));
    add(0, 1, 0, 64'h0,      0, 1, 0, rep(4'hC));
    add(0, 1, 0, 64'h0,      0, 1, 0, rep(4'hC));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hD));
    add(0, 1, 1, 64'h0,      0, 0, 1, 64'h0);
    add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0);
    b_hi = vecs.size();

    // C: read and write together; only the read runs.
    c_lo = vecs.size();
    add(1, 1, 0, 64'h0,      1, 0, 0, 64'h0);
    add(1, 1, 1, rep(4'h5),  1, 0, 0, 64'h0);
    add(1, 1, 1, rep(4'h6),  1, 0, 0, 64'h0);
    add(1, 1, 1, rep(4'h7),  1, 0, 0, 64'h0);
    add(1, 1, 1, rep(4'h8),  0, 0, 1, 64'h0);
    add(1, 1, 0, 64'h0,      0, 0, 0, 64'h0);
    add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0);
    c_hi = vecs.size();

    // D: spurious resp_i in IDLE/DONE, then back-to-back read and write.
    d_lo = vecs.size();
    add(0, 0, 1, rep(4'hE),  0, 0, 0, 64'h0);
    add(0, 0, 1, rep(4'hE),  0, 0, 0, 64'h0);
    add(1, 0, 0, 64'h0,      1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'h9),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'hA),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'hB),  1, 0, 0, 64'h0);
    add(1, 0, 1, rep(4'hC),  0, 0, 1, 64'h0);
    add(1, 0, 1, rep(4'hF),  0, 0, 0, 64'h0);
    d_mid = vecs.size();
    add(0, 1, 1, rep(4'hF),  0, 1, 0, rep(4'hA));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hB));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hC));
    add(0, 1, 1, 64'h0,      0, 1, 0, rep(4'hD));
    add(0, 1, 1, 64'h0,      0, 0, 1, 64'h0);
    add(0, 0, 0, 64'h0,      0, 0, 0, 64'h0);
    d_hi = vecs.size();

    rst_n     = 1'b0;
    address_i = 32'h0;
    line_i    = '0;
    read_i    = 1'b0;
    write_i   = 1'b0;
    resp_i    = 1'b0;
    burst_i   = '0;
    #3;
    chk("rst.resp_o", 256'(resp_o), 256'(0));
    chk("rst.read_o", 256'(read_o), 256'(0));
    chk("rst.write_o", 256'(write_o), 256'(0));
    chk("rst.address_o", 256'(address_o), 256'(0));
    chk("rst.burst_o", 256'(burst_o), 256'(0));
    chk("rst.line_o", line_o, 256'(0));
    step();
    step();
    rst_n = 1'b1;

    address_i = 32'h0000_1234;
    run_seg("rd", a_lo, a_hi);
    chk("rd.address_o", 256'(address_o), 256'(32'h0000_1220));
    chk("rd.line_o", line_o, {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)});

    address_i = 32'h0000_ABCD;
    line_i    = wline;
    run_seg("wr", b_lo, b_hi);
    chk("wr.address_o", 256'(address_o), 256'(32'h0000_ABC0));
    chk("wr.line_o", line_o, wline);

    address_i = 32'h0000_0100;
    line_i    = ~wline;
    run_seg("both", c_lo, c_hi);
    chk("both.address_o", 256'(address_o), 256'(32'h0000_0100));
    chk("both.line_o", line_o, {rep(4'h8), rep(4'h7), rep(4'h6), rep(4'h5)});

    address_i = 32'h0000_0040;
    line_i    = wline;
    run_seg("b2b", d_lo, d_mid);
    chk("b2b.read_line", line_o, {rep(4'hC), rep(4'hB), rep(4'hA), rep(4'h9)});
    run_seg("b2b", d_mid, d_hi);
    chk("b2b.write_line", line_o, wline);

    // Reset in the middle of a read, after two beats.
    address_i = 32'h0000_2000;
    read_i    = 1'b1;
    resp_i    = 1'b0;
    step();
    resp_i  = 1'b1;
    burst_i = rep(4'h1);
    step();
    burst_i = rep(4'h2);
    step();
    chk("mid.read_o_before", 256'(read_o), 256'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid.read_o", 256'(read_o), 256'(0));
    chk("mid.resp_o", 256'(resp_o), 256'(0));
    chk("mid.line_o", line_o, 256'(0));
    chk("mid.address_o", 256'(address_o), 256'(0));
    read_i = 1'b0;
    resp_i = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("mid.idle_resp_o", 256'(resp_o), 256'(0));
    address_i = 32'h0000_1234;
    run_seg("post", a_lo, a_hi);
    chk("post.line_o", line_o, {rep(4'h4), rep(4'h3), rep(4'h2), rep(4'h1)});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
